ext_bus_bridge: RTL and testbench
=================================

# ext_bus_bridge

Registered bridge between the memory controller's external request port and the off-core memory bus. It accepts one request at a time and re-drives it from flops. It rejects illegal byte-enable/alignment combinations without touching the external bus, bounds every external transaction with a timeout, and returns a one-cycle acknowledge, with an error flag, to the memory controller.

## Interface
- TIMEOUT_CYCLES, 256: maximum cycles `o_bus_en` stays high without `i_ack` before the bridge aborts; legal range 2..65536.
- ERR_RDATA, 32'h0000_0000: value returned on `o_rd_data` with an error response.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_bus_en  in  1  upstream request valid; held with stable fields until `o_ack`.
- i_wr_en  in  1  1 = write, 0 = read.
- i_wr_data  in  32  write data.
- i_addr  in  32  byte address.
- i_byte_en  in  4  byte lanes.
- o_ack  out  1  one-cycle response pulse to upstream.
- o_rd_data  out  32  read data, valid while `o_ack`=1.
- o_err  out  1  qualifies `o_ack`: 1 = illegal access or timeout.
- o_err_addr  out  32  sticky address of the most recent errored request.
- o_bus_en, o_wr_en, o_wr_data[32], o_addr[32], o_byte_en[4]  out  external request, all driven from flops.
- i_ack  in  1  external acknowledge.
- i_rd_data  in  32  external read data, valid with `i_ack`.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: if `i_bus_en`=1 at an edge, capture the request fields.
  - Legal: `i_byte_en` ∈ {0001, 0010, 0100, 1000} with any `addr[1:0]`; {0011, 1100} with `addr[0]`=0; {1111} with `addr[1:0]`=0. Go to REQ.
  - Illegal: any other pattern, including 0000. Go to RESP with error; no external request is issued.
- REQ: `o_bus_en`=1 and the external fields hold the captured values. Timeout counter increments each REQ cycle.
  - `i_ack`=1: latch `i_rd_data` (reads only; writes return 0) and go to RESP with err=0.
  - Counter = TIMEOUT_CYCLES-1 and `i_ack`=0: go to RESP with err=1 and drive ERR_RDATA.
- RESP: `o_ack`=1 for exactly one cycle, `o_err`/`o_rd_data` per the captured result. On error, `o_err_addr` is loaded with the captured address. Next state is IDLE unconditionally.
- Upstream holds `i_bus_en` through the `o_ack` cycle. The cycle after `o_ack`, `i_bus_en` is treated as a new request.
- `i_ack` outside REQ is ignored. A late ack after a timeout does not produce a second `o_ack`.
- Counter width is clog2(TIMEOUT_CYCLES). It clears on entry to REQ and never wraps, because the abort occurs at TIMEOUT_CYCLES-1.

## Timing
- Reset (`i_rst`=0 at an edge): state IDLE; `o_ack`, `o_err`, `o_bus_en`, `o_wr_en` = 0; `o_wr_data`, `o_addr`, `o_rd_data`, `o_err_addr` = 0; `o_byte_en` = 0; counter = 0.
- Reset mid-transaction drops the external request at the next edge. No `o_ack` is produced for the aborted request.
- Legal request, `i_bus_en` high in cycle 0:
  - `o_bus_en` high from cycle 1.
  - External ack in cycle k (k≥1) gives `o_ack` in cycle k+1, with `o_bus_en` low in cycle k+1.
  - Minimum latency: 2 cycles.
- Illegal request: `o_ack`+`o_err` in cycle 1; `o_bus_en` stays 0 throughout.
- Timeout: with `o_bus_en` high cycles 1..TIMEOUT_CYCLES, `o_ack`+`o_err` occurs in cycle TIMEOUT_CYCLES+1.
- `i_ack` in the same cycle the counter hits its limit: ack wins, err=0.
- Back-to-back requests: minimum spacing of 3 cycles per transaction (IDLE, REQ, RESP).
- External fields only change on entry to REQ, so they are stable for the whole time `o_bus_en` is high.

## Structure
- Shared package `arvi_bus_pkg`:
  - state enum `bridge_state_t` {IDLE, REQ, RESP}.
  - function `byte_en_legal(addr[1:0], byte_en)`.
  - constant `BUS_ERR_RDATA_DEFAULT`.
- One sub-module, `bus_timeout_ctr`:
  - parameter LIMIT; inputs `clear`, `enable`; output `expired`.
  - synchronous active-low reset.
- FSM, capture registers, and response registers stay in `ext_bus_bridge`.

## Test plan
- Word read at 0x0000_1000, `byte_en` 1111, external ack one cycle after `o_bus_en` rises with data 0xCAFE_F00D -> `o_ack` in cycle 3, `o_rd_data`=0xCAFE_F00D, `o_err`=0.
- Halfword write to 0x0000_2002, `byte_en` 1100, data 0x1234_0000, immediate ack -> external `o_addr`/`o_byte_en`/`o_wr_data` match the request while `o_bus_en` is high; `o_ack` in cycle 2, `o_err`=0.
- Illegal `byte_en` 0110 at 0x0000_3000 -> `o_ack`+`o_err` in cycle 1, `o_bus_en` never asserts, `o_err_addr`=0x0000_3000, `o_rd_data`=ERR_RDATA.
- TIMEOUT_CYCLES=4, external never acks -> `o_bus_en` high cycles 1-4, `o_ack`+`o_err` in cycle 5. A late `i_ack` in cycle 6 produces no extra `o_ack`.
- Ack and timeout on the same cycle (TIMEOUT_CYCLES=4, ack in cycle 4) -> `o_err`=0, read data returned.
- `i_rst` low while in REQ -> next cycle all outputs 0. A new request issued after reset completes normally with a single `o_ack`.

Source files
------------

// File: rtl/ext_bus_bridge_pkg.sv
// Shared definitions for the external bus bridge.
//   bridge_state_t        : bridge FSM state encoding
//   BUS_ERR_RDATA_DEFAULT : read data returned with an error response
//   byte_en_legal()       : byte-lane / address alignment rule
package arvi_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } bridge_state_t;

    localparam logic [31:0] BUS_ERR_RDATA_DEFAULT = 32'h0000_0000;

    // Single lanes are legal at any address, halfword pairs need an even
    // address, and the full word needs a word-aligned address.
    function automatic logic byte_en_legal(input logic [1:0] addr_lo,
                                           input logic [3:0] byte_en);
        logic ok;
        case (byte_en)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            4'b0011, 4'b1100:                   ok = ~addr_lo[0];
            4'b1111:                            ok = (addr_lo == 2'b00);
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ext_bus_bridge_timeout_ctr.sv
// Timeout counter for one external bus transaction.
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   clear   : restart the count at zero (has priority over enable)
//   enable  : count one cycle
//   expired : count has reached LIMIT-1
module bus_timeout_ctr #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int          W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // Holding at LAST keeps the counter from wrapping even if the owner
    // were to leave enable high past expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/ext_bus_bridge.sv
// Registered bridge from the memory controller request port to the off-core
// memory bus. One request at a time; illegal lane/alignment combinations are
// answered with an error without touching the bus, and every external
// transaction is bounded by a timeout.
//   i_clk, i_rst                : clock, synchronous active-low reset
//   i_bus_en .. i_byte_en       : upstream request (held until o_ack)
//   o_ack, o_rd_data, o_err     : one-cycle upstream response
//   o_err_addr                  : sticky address of the last errored request
//   o_bus_en .. o_byte_en       : external request, driven from flops
//   i_ack, i_rd_data            : external acknowledge and read data
module ext_bus_bridge
    import arvi_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = BUS_ERR_RDATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_byte_en,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic        o_err,
    output logic [31:0] o_err_addr,
    output logic        o_bus_en,
    output logic        o_wr_en,
    output logic [31:0] o_wr_data,
    output logic [31:0] o_addr,
    output logic [3:0]  o_byte_en,
    input  logic        i_ack,
    input  logic [31:0] i_rd_data
);

    bridge_state_t state, state_next;

    logic req_legal;
    logic load_req;
    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expired;
    logic done_ok;
    logic done_err;

    assign req_legal = byte_en_legal(i_addr[1:0], i_byte_en);

    bus_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state)
            IDLE: begin
                // Counter sits at zero while idle, so it starts clean in REQ.
                cnt_clear = 1'b1;
                if (i_bus_en) begin
                    if (req_legal) begin
                        load_req   = 1'b1;
                        state_next = REQ;
                    end else begin
                        done_err   = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            REQ: begin
                cnt_enable = 1'b1;
                // An ack on the last allowed cycle still counts as success.
                if (i_ack) begin
                    done_ok    = 1'b1;
                    state_next = RESP;
                end else if (cnt_expired) begin
                    done_err   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // External fields change only when a legal request is accepted, so they
    // are stable for the whole time o_bus_en is high. Response registers are
    // loaded on the edge entering RESP so they are valid during o_ack.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_bus_en   <= 1'b0;
            o_wr_en    <= 1'b0;
            o_wr_data  <= '0;
            o_addr     <= '0;
            o_byte_en  <= '0;
            o_ack      <= 1'b0;
            o_err      <= 1'b0;
            o_rd_data  <= '0;
            o_err_addr <= '0;
        end else begin
            o_bus_en <= (state_next == REQ);
            o_ack    <= done_ok | done_err;
            o_err    <= done_err;
            if (load_req) begin
                o_wr_en   <= i_wr_en;
                o_wr_data <= i_wr_data;
                o_addr    <= i_addr;
                o_byte_en <= i_byte_en;
            end
            if (done_ok) begin
                o_rd_data <= o_wr_en ? 32'h0000_0000 : i_rd_data;
            end else if (done_err) begin
                o_rd_data <= ERR_RDATA;
            end
            // Illegal requests never reach o_addr, so take their address
            // straight from the upstream port.
            if (done_err) begin
                o_err_addr <= (state == IDLE) ? i_addr : o_addr;
            end
        end
    end

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Self-checking bench for ext_bus_bridge: directed cases followed by random
// transactions, with expected responses queued at issue time and checked by
// a monitor whenever the bridge acknowledges.
module tb_ext_bus_bridge;

    localparam int          TO      = 4;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_bus_en;
    logic        i_wr_en;
    logic [31:0] i_wr_data;
    logic [31:0] i_addr;
    logic [3:0]  i_byte_en;
    logic        o_ack;
    logic [31:0] o_rd_data;
    logic        o_err;
    logic [31:0] o_err_addr;
    logic        o_bus_en;
    logic        o_wr_en;
    logic [31:0] o_wr_data;
    logic [31:0] o_addr;
    logic [3:0]  o_byte_en;
    logic        i_ack;
    logic [31:0] i_rd_data;

    ext_bus_bridge #(
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR_VAL)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_bus_en   (i_bus_en),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_addr     (i_addr),
        .i_byte_en  (i_byte_en),
        .o_ack      (o_ack),
        .o_rd_data  (o_rd_data),
        .o_err      (o_err),
        .o_err_addr (o_err_addr),
        .o_bus_en   (o_bus_en),
        .o_wr_en    (o_wr_en),
        .o_wr_data  (o_wr_data),
        .o_addr     (o_addr),
        .o_byte_en  (o_byte_en),
        .i_ack      (i_ack),
        .i_rd_data  (i_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic [31:0] ea;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_err_addr = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Legal iff the enabled lanes form one naturally aligned group of 1, 2
    // or 4 bytes and the address is a multiple of that size.
    function automatic bit model_legal(input logic [31:0] a, input logic [3:0] be);
        int sz;
        sz = $countones(be);
        if (!(sz == 1 || sz == 2 || sz == 4)) return 1'b0;
        for (int j = 0; j < 4 / sz; j++) begin
            if (int'(be) == (((1 << sz) - 1) << (sz * j))) return (int'(a[1:0]) % sz) == 0;
        end
        return 1'b0;
    endfunction

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(o_ack), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_err", 32'(o_err), 32'(e.err));
                    check("resp_rd_data", o_rd_data, e.rd);
                    check("resp_err_addr", o_err_addr, e.ea);
                end
            end
        end
    endtask

    // Called at #1 after a rising edge; that cycle is request cycle 0.
    // ack_at: cycle in which the external slave acks (-1 = never).
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata,
                           input logic late_ack, input int gap);
        bit   legal;
        int   exp_lat;
        int   seen;
        exp_t e;
        legal = model_legal(addr, be);
        if (!legal) begin
            exp_lat = 1;
        end else if (ack_at >= 1 && ack_at <= TO) begin
            exp_lat = ack_at + 1;
        end else begin
            exp_lat = TO + 1;
        end
        e.err = !(legal && ack_at >= 1 && ack_at <= TO);
        e.rd  = e.err ? ERR_VAL : (wr ? 32'h0 : rdata);
        if (e.err) model_err_addr = addr;
        e.ea  = model_err_addr;
        exp_q.push_back(e);

        i_bus_en  = 1'b1;
        i_wr_en   = wr;
        i_addr    = addr;
        i_byte_en = be;
        i_wr_data = wdata;
        seen      = -1;
        for (int c = 0; c <= TO + 3 && seen < 0; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            i_ack     = (c == ack_at);
            i_rd_data = (c == ack_at) ? rdata : $urandom;
            @(negedge clk);
            check("bus_en", 32'(o_bus_en), 32'(legal && c >= 1 && c < exp_lat));
            if (o_bus_en === 1'b1) begin
                check("ext_fields", {o_wr_en, o_byte_en, o_addr[26:0]} ^ o_wr_data,
                      {wr, be, addr[26:0]} ^ wdata);
                check("ext_addr", o_addr, addr);
            end
            if (o_ack === 1'b1) seen = c;
        end
        check("ack_latency", 32'(seen), 32'(exp_lat));
        @(posedge clk);
        #1;
        i_ack = 1'b0;
        if (gap > 0) begin
            i_bus_en  = 1'b0;
            i_addr    = $urandom;
            i_byte_en = 4'($urandom);
            i_ack     = late_ack;
            i_rd_data = $urandom;
            @(negedge clk);
            check("idle_no_ack", 32'(o_ack), 32'h0);
            @(posedge clk);
            #1;
            i_ack = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 32'({o_ack, o_err, o_bus_en, o_wr_en, o_byte_en}), 32'h0);
        check({name, "_wr_data"}, o_wr_data, 32'h0);
        check({name, "_addr"}, o_addr, 32'h0);
        check({name, "_rd_data"}, o_rd_data, 32'h0);
        check({name, "_err_addr"}, o_err_addr, 32'h0);
    endtask

    logic [3:0] be_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    initial begin
        logic [3:0]  be;
        logic [31:0] addr;
        int          ack_at;

        i_rst     = 1'b0;
        i_bus_en  = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_data = '0;
        i_addr    = '0;
        i_byte_en = '0;
        i_ack     = 1'b0;
        i_rd_data = '0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk);
        #1;

        // Word read, ack one cycle after o_bus_en rises.
        run_txn(1'b0, 32'h0000_1000, 4'b1111, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1);
        // Halfword write, immediate ack.
        run_txn(1'b1, 32'h0000_2002, 4'b1100, 32'h1234_0000, 1, 32'h5555_AAAA, 1'b0, 1);
        // Illegal lanes.
        run_txn(1'b0, 32'h0000_3000, 4'b0110, 32'h0, 1, 32'h1111_1111, 1'b0, 1);
        // Timeout, then a late ack that must be ignored.
        run_txn(1'b0, 32'h0000_4000, 4'b0001, 32'h0, -1, 32'h0, 1'b1, 1);
        // Ack on the same cycle the counter reaches its limit.
        run_txn(1'b0, 32'h0000_5004, 4'b1111, 32'h0, TO, 32'h0BAD_CAFE, 1'b0, 1);
        // Empty lane mask and misaligned word.
        run_txn(1'b1, 32'h0000_6000, 4'b0000, 32'h0, 1, 32'h0, 1'b0, 0);
        run_txn(1'b0, 32'h0000_6002, 4'b1111, 32'h0, 1, 32'h0, 1'b0, 1);

        // Reset while the external request is outstanding.
        i_bus_en  = 1'b1;
        i_wr_en   = 1'b0;
        i_addr    = 32'h0000_7000;
        i_byte_en = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        i_rst    = 1'b1;
        i_bus_en = 1'b0;
        model_err_addr = 32'h0;
        @(negedge clk);
        check_all_zero("reset_mid_req");
        @(posedge clk);
        #1;
        run_txn(1'b0, 32'h0000_7000, 4'b1111, 32'h0, 3, 32'h7777_0001, 1'b0, 1);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            addr = $urandom;
            be   = ($urandom_range(0, 1) == 0) ? 4'($urandom) : be_tab[$urandom_range(0, 6)];
            ack_at = $urandom_range(1, TO + 2);
            if (ack_at == TO + 2) ack_at = -1;
            run_txn(1'($urandom), addr, be, $urandom, ack_at, $urandom,
                    1'($urandom), $urandom_range(0, 1));
        end

        i_bus_en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
